mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported simulation memory (one read port, one write port, word-aligned) between the instruction-fetch requester and the load/store requester of the multicycle CPU.
- Arbitrates requests and latches address and data at grant.
- Sequences a programmable wait-state access, then returns a one-cycle acknowledge with read data.
- Sits between the control/datapath and the memory instance; address translation stays inside the memory.

Parameters:
W, 32, word width of addresses and data
LATENCY, 2, memory wait cycles per access; legal range 1..15
STARVE_LIMIT, 4, consecutive contested data grants allowed before instruction is forced to win; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  instruction fetch request
i_addr  in  W  fetch byte address
i_rdata  out  W  fetched word
i_ack  out  1  fetch complete, one-cycle pulse
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  W  data byte address
d_wdata  in  W  store data
d_rdata  out  W  loaded word
d_ack  out  1  data access complete, one-cycle pulse
mem_read_en  out  1  memory read enable
mem_read_addr  out  W  memory read address
mem_read_data  in  W  memory read data (combinational from address)
mem_write_en  out  1  memory write enable, sampled at clk edge
mem_write_addr  out  W  memory write address
mem_write_data  out  W  memory write data
busy  out  1  arbiter not idle

Behaviour:
Reset values:
- FSM = IDLE; wait counter = 0; starve counter = 0.
- All outputs 0, including i_rdata and d_rdata.

Handshake:
- Requester holds req, addr, we and wdata stable until it sees ack.
- Requester deasserts req in the cycle after ack unless it is issuing a new request.
- Inputs are latched into internal registers at grant; changes after grant are ignored.

FSM states:
- IDLE:
  - If neither req is high, stay in IDLE.
  - If only one req is high, grant it.
  - If both are high, grant data unless starve counter == STARVE_LIMIT, in which case grant instruction.
  - On grant: latch grant id, addr, we and wdata; load wait counter = LATENCY-1; go to WAIT.
- WAIT:
  - Read access: mem_read_en = 1 and mem_read_addr = latched addr for every WAIT cycle.
  - Write access: mem_write_addr and mem_write_data driven from latches; mem_write_en = 1 only in the final WAIT cycle (counter == 0), so exactly one write edge occurs.
  - Counter decrements each cycle.
  - At counter == 0, a read captures mem_read_data into i_rdata or d_rdata (per grant); then go to DONE.
- DONE:
  - Assert i_ack or d_ack (per grant) for exactly this cycle.
  - Go to IDLE.

Outputs and ordering:
- All mem_* enables are registered decodes of state, glitch-free; no combinational path from req to mem_*.
- busy = (state != IDLE).
- Latency: req sampled in IDLE at cycle 0, ack asserted in cycle LATENCY+1.
- One access per LATENCY+2 cycles.
- i_rdata and d_rdata hold their value until the next read completes on that channel; stores do not change d_rdata.

Starvation counter:
- Increments when data is granted while i_req is high (saturates at STARVE_LIMIT).
- Clears to 0 on any instruction grant.
- Unchanged on an uncontested data grant.

Address:
- Passed through unmodified; alignment and low bits are handled by the memory.
- Misaligned addresses are not flagged.

Reset mid-operation:
- FSM returns to IDLE immediately.
- An in-progress access is abandoned with no ack.
- mem_write_en drops asynchronously, so no partial write occurs after rst rises.

Illegal parameters:
- LATENCY = 0 or LATENCY > 15 is a simulation-time fatal error.
- STARVE_LIMIT = 0 or STARVE_LIMIT > 15 is a simulation-time fatal error.

Test Plan:
- Single fetch: LATENCY=2, i_req=1, i_addr=0x0000_0004, mem word1 = 0x2408_0005 -> i_ack pulse exactly 3 cycles after request cycle, i_rdata = 0x2408_0005, mem_write_en never asserted.
- Store then load: d_we=1, d_addr=0x1001_0000, d_wdata=0xDEAD_BEEF -> mem_write_en high one cycle, d_ack, d_rdata unchanged; then load from the same address -> d_rdata = 0xDEAD_BEEF.
- Contention: i_req and d_req held high continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; no ack ever overlaps another ack.
- Reset mid-write: assert rst during the first WAIT cycle of a store -> mem_write_en never pulses, memory word unchanged, no d_ack, all outputs 0 after rst.
- Input change after grant: change d_addr and d_wdata one cycle after grant -> write uses the originally latched values.
- LATENCY=1 build: back-to-back fetches -> i_ack every 3 cycles, busy low for exactly one cycle between accesses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory (one read port, one write port) between the
// instruction-fetch requester and the load/store requester of the multicycle CPU.
// Each access runs IDLE -> WAIT (LATENCY cycles) -> DONE (one-cycle ack).
//
// Handshake: a requester raises req with addr/we/wdata and holds them until it
// sees its ack pulse. The arbiter latches the request when it grants, in IDLE,
// and ignores later input changes. The ack is high for exactly one cycle, in
// DONE. The requester drops req in the cycle after ack, or keeps it high to
// issue its next request.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   i_req, i_addr                   fetch request / byte address
//   i_rdata, i_ack                  fetched word / completion pulse
//   d_req, d_we, d_addr, d_wdata    data request (d_we=1 store, 0 load)
//   d_rdata, d_ack                  loaded word / completion pulse
//   mem_read_en/addr/data           memory read port (data is combinational)
//   mem_write_en/addr/data          memory write port (sampled at clk edge)
//   busy                            arbiter not idle
module mem_arbiter #(
   parameter int W            = 32,
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_req,
   input  logic [W-1:0] i_addr,
   output logic [W-1:0] i_rdata,
   output logic         i_ack,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [W-1:0] d_addr,
   input  logic [W-1:0] d_wdata,
   output logic [W-1:0] d_rdata,
   output logic         d_ack,
   output logic         mem_read_en,
   output logic [W-1:0] mem_read_addr,
   input  logic [W-1:0] mem_read_data,
   output logic         mem_write_en,
   output logic [W-1:0] mem_write_addr,
   output logic [W-1:0] mem_write_data,
   output logic         busy
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "mem_arbiter: LATENCY must be in 1..15");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $fatal(1, "mem_arbiter: STARVE_LIMIT must be in 1..15");
   end

   localparam logic [3:0] LAT_M1     = 4'(LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   starve_q, starve_d;
   logic         gnt_data_q, gnt_data_d;   // 1 = data channel owns the access
   logic         we_q, we_d;
   logic [W-1:0] addr_q, addr_d;
   logic [W-1:0] wdata_q, wdata_d;
   logic [W-1:0] i_rdata_q, i_rdata_d;
   logic [W-1:0] d_rdata_q, d_rdata_d;
   logic         mem_read_en_q, mem_read_en_d;
   logic         mem_write_en_q, mem_write_en_d;
   logic         pick_data;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      starve_d       = starve_q;
      gnt_data_d     = gnt_data_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      i_rdata_d      = i_rdata_q;
      d_rdata_d      = d_rdata_q;
      mem_read_en_d  = 1'b0;
      mem_write_en_d = 1'b0;
      // Data wins contention unless the fetch side has been passed over
      // STARVE_LIMIT times in a row.
      pick_data      = d_req && !(i_req && (starve_q == STARVE_MAX));

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               gnt_data_d = pick_data;
               we_d       = pick_data && d_we;
               addr_d     = pick_data ? d_addr : i_addr;
               wdata_d    = pick_data ? d_wdata : wdata_q;
               cnt_d      = LAT_M1;
               state_d    = S_WAIT;
               if (!pick_data) begin
                  starve_d = 4'd0;
               end else if (i_req && (starve_q < STARVE_MAX)) begin
                  starve_d = starve_q + 4'd1;
               end
               // Enables are registered: decide now what the first WAIT cycle drives.
               mem_read_en_d  = !(pick_data && d_we);
               mem_write_en_d = (pick_data && d_we) && (LAT_M1 == 4'd0);
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               if (!we_q) begin
                  if (gnt_data_q) begin
                     d_rdata_d = mem_read_data;
                  end else begin
                     i_rdata_d = mem_read_data;
                  end
               end
            end else begin
               cnt_d          = cnt_q - 4'd1;
               mem_read_en_d  = !we_q;
               // Write enable lands only on the last WAIT cycle: a single write edge.
               mem_write_en_d = we_q && (cnt_q == 4'd1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         starve_q       <= 4'd0;
         gnt_data_q     <= 1'b0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         mem_read_en_q  <= 1'b0;
         mem_write_en_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         starve_q       <= starve_d;
         gnt_data_q     <= gnt_data_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         i_rdata_q      <= i_rdata_d;
         d_rdata_q      <= d_rdata_d;
         mem_read_en_q  <= mem_read_en_d;
         mem_write_en_q <= mem_write_en_d;
      end
   end

   assign i_rdata        = i_rdata_q;
   assign d_rdata        = d_rdata_q;
   assign i_ack          = (state_q == S_DONE) && !gnt_data_q;
   assign d_ack          = (state_q == S_DONE) && gnt_data_q;
   assign mem_read_en    = mem_read_en_q;
   assign mem_read_addr  = addr_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_write_addr = addr_q;
   assign mem_write_data = wdata_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LATENCY=2 instance with a small word memory model,
// and a LATENCY=1 instance for back-to-back fetch timing.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // ---------------- LATENCY=2 instance ----------------
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata;
   logic        i_ack, d_ack, busy;
   logic        mem_read_en, mem_write_en;
   logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;

   mem_arbiter #(.W(32), .LATENCY(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data),
      .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data),
      .busy(busy)
   );

   // ---------------- LATENCY=1 instance ----------------
   logic        i1_req, d1_req, d1_we;
   logic [31:0] i1_addr, d1_addr, d1_wdata;
   logic [31:0] i1_rdata, d1_rdata;
   logic        i1_ack, d1_ack, busy1;
   logic        mem1_read_en, mem1_write_en;
   logic [31:0] mem1_read_addr, mem1_read_data, mem1_write_addr, mem1_write_data;

   mem_arbiter #(.W(32), .LATENCY(1), .STARVE_LIMIT(4)) dut1 (
      .clk(clk), .rst(rst),
      .i_req(i1_req), .i_addr(i1_addr), .i_rdata(i1_rdata), .i_ack(i1_ack),
      .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
      .d_rdata(d1_rdata), .d_ack(d1_ack),
      .mem_read_en(mem1_read_en), .mem_read_addr(mem1_read_addr),
      .mem_read_data(mem1_read_data),
      .mem_write_en(mem1_write_en), .mem_write_addr(mem1_write_addr),
      .mem_write_data(mem1_write_data),
      .busy(busy1)
   );
   assign mem1_read_data = mem1_read_addr ^ 32'hA5A5_0000;

   // ---------------- memory model (256 words, index = addr[9:2]) ----------------
   logic [31:0] mem [0:255];
   logic        mem_loaded = 1'b0;
   int          wr_cnt = 0;
   int          d_ack_cnt = 0;

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      case (i)
         1:       return 32'h2408_0005;
         2:       return 32'h8C09_0000;
         3:       return 32'h0000_0333;
         default: return {24'h00C0DE, b};
      endcase
   endfunction

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_loaded <= 1'b1;
      end else if (mem_write_en) begin
         mem[mem_write_addr[9:2]] <= mem_write_data;
      end
      if (mem_write_en) wr_cnt <= wr_cnt + 1;
      if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
   end
   assign mem_read_data = mem[mem_read_addr[9:2]];

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;   // i_rdata (fetch) or d_rdata (data) after ack
      int          exp_writes;
   } vec_t;

   vec_t vecs[8];

   // One uncontested access on the LATENCY=2 instance, started at a negedge.
   task automatic run_vec(input int idx, input vec_t v);
      int n;
      bit got;
      int wr0;
      wr0 = wr_cnt;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (n == 1) begin
            check($sformatf("vec%0d_busy", idx), 32'(busy), 32'd1);
            if (v.we) begin
               check($sformatf("vec%0d_wr_addr", idx), mem_write_addr, v.addr);
               check($sformatf("vec%0d_wr_data", idx), mem_write_data, v.wdata);
            end else begin
               check($sformatf("vec%0d_rd_addr", idx), mem_read_addr, v.addr);
               check($sformatf("vec%0d_rd_en", idx), 32'(mem_read_en), 32'd1);
            end
         end
         if (v.is_d ? d_ack : i_ack) got = 1'b1;
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      check($sformatf("vec%0d_ack_seen", idx), 32'(got), 32'd1);
      check($sformatf("vec%0d_latency", idx), 32'(n), 32'd3);
      check($sformatf("vec%0d_rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
      check($sformatf("vec%0d_writes", idx), 32'(wr_cnt - wr0), 32'(v.exp_writes));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", idx), 32'(busy), 32'd0);
   endtask

   initial begin
      logic [0:0] exp_q[$];
      logic [0:0] got_q[$];
      int         overlaps;
      int         n;
      bit         got;
      int         nack;
      int         wr0;
      int         dack0;

      rst = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      i1_req = 0; i1_addr = 0; d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          32'h2408_0005, 0};
      vecs[1] = '{1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1};
      vecs[2] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0,          32'hDEAD_BEEF, 0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          32'h8C09_0000, 0};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_000E, 32'h0,          32'h0000_0333, 0};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 1};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'h1234_5678, 0};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          32'h2408_0005, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
      check("rst_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table: uncontested accesses (ends on data grants so starve stays 0)
      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);
      check("i_rdata_kept", i_rdata, 32'h0000_0333);

      // Contention: both requesters held high
      exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      got_q = {};
      overlaps = 0;
      i_req = 1; i_addr = 32'h0000_0008;
      d_req = 1; d_we = 0; d_addr = 32'h1001_0000;
      for (int c = 0; c < 200 && got_q.size() < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (i_ack && d_ack) overlaps++;
         if (i_ack) got_q.push_back(1'b1);
         if (d_ack) got_q.push_back(1'b0);
      end
      i_req = 0; d_req = 0;
      check("contention_count", 32'(got_q.size()), 32'd10);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("grant_order%0d", k), (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF_FFFF,
               32'(exp_q[k]));
      end
      check("ack_overlaps", 32'(overlaps), 32'd0);
      check("contention_i_rdata", i_rdata, 32'h8C09_0000);
      check("contention_d_rdata", d_rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      @(negedge clk);

      // Inputs changed one cycle after grant must not affect the store
      d_req = 1; d_we = 1; d_addr = 32'h0000_0080; d_wdata = 32'hCAFE_0001;
      @(posedge clk);
      @(negedge clk);
      d_addr = 32'h0000_0084; d_wdata = 32'h0BAD_BAD0;
      n = 1;
      got = d_ack;
      while (!got && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         got = d_ack;
      end
      d_req = 0; d_we = 0;
      check("latch_ack_seen", 32'(got), 32'd1);
      check("latch_mem80", mem[32], 32'hCAFE_0001);
      check("latch_mem84", mem[33], 32'h00C0_DE21);
      check("latch_d_rdata", d_rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      @(negedge clk);

      // Reset during the first WAIT cycle of a store
      wr0 = wr_cnt;
      dack0 = d_ack_cnt;
      d_req = 1; d_we = 1; d_addr = 32'h0000_0040; d_wdata = 32'h5555_AAAA;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_write_en", 32'(mem_write_en), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      d_req = 0; d_we = 0;
      check("midrst_d_ack", 32'(d_ack), 32'd0);
      check("midrst_rdata", i_rdata | d_rdata, 32'd0);
      check("midrst_mem_addr", mem_read_addr | mem_write_addr | mem_write_data, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
      check("midrst_mem40", mem[16], 32'h00C0_DE10);
      check("midrst_no_ack", 32'(d_ack_cnt - dack0), 32'd0);
      check("midrst_idle", 32'(busy), 32'd0);

      // LATENCY=1: back-to-back fetches, ack every 3 cycles
      nack = 0;
      i1_req = 1; i1_addr = 32'h0000_0100;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("lat1_busy%0d", k), 32'(busy1), 32'((k % 3) != 0));
         check($sformatf("lat1_ack%0d", k), 32'(i1_ack), 32'((k % 3) == 2));
         if (i1_ack) begin
            check($sformatf("lat1_rdata%0d", nack), i1_rdata,
                  (32'h0000_0100 + 32'(4 * nack)) ^ 32'hA5A5_0000);
            nack++;
            i1_addr = i1_addr + 32'd4;
         end
      end
      i1_req = 0;
      check("lat1_no_d_ack", {31'd0, d1_ack}, 32'd0);
      check("lat1_no_write", {31'd0, mem1_write_en}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
